// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_I,
      ISSUE_D,
      RESP
   } arb_state_t;

   // Latched memory command; field order matches the mem_we/mem_addr/mem_wdata bus.
   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } mem_req_t;

   function automatic logic is_issue(arb_state_t s);
      return (s == ISSUE_I) || (s == ISSUE_D);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory handshake bundle for the memory port arbiter.
// slave is the arbiter's view; master is the view of the core plus memory.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              halted;
   logic              if_req;
   logic [WORD_W-1:0] if_addr;
   logic              if_ack;
   logic [WORD_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [WORD_W-1:0] d_addr;
   logic [WORD_W-1:0] d_wdata;
   logic              d_ack;
   logic [WORD_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_err;

   modport slave (
      input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
             mem_rdata, mem_ready,
      output if_ack, if_rdata, d_ack, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_err
   );

   modport master (
      output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
             mem_rdata, mem_ready,
      input  if_ack, if_rdata, d_ack, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_err
   );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Watchdog for one memory transaction: loaded when a transaction is granted,
// counts down while the transaction is issued, expire marks its last allowed cycle.
module arb_timeout_counter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   // Reload on grant, then count down once per issue cycle and stop at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(TIMEOUT - 1);
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = run && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; a streak limit forces a pending fetch through, and a
// watchdog aborts transactions the memory never completes.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t        state;
   mem_req_t          cmd;
   logic              mem_req_q;
   logic              if_ack_q;
   logic              d_ack_q;
   logic              mem_err_q;
   logic [WORD_W-1:0] if_rdata_q;
   logic [WORD_W-1:0] d_rdata_q;
   logic [SW-1:0]     streak;

   logic              if_ok;
   logic              force_i;
   logic              grant_d;
   logic              grant_i;
   logic              expire;

   // Grant decision, only meaningful while IDLE.
   always_comb begin
      if_ok   = 1'b0;
      force_i = 1'b0;
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state == IDLE) begin
         if_ok   = bus.if_req && !bus.halted;
         force_i = if_ok && (streak == SW'(STARVE_LIMIT));
         if (bus.d_req && !force_i) begin
            grant_d = 1'b1;
         end else if (if_ok) begin
            grant_i = 1'b1;
         end
      end
   end

   arb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (grant_d || grant_i),
      .run    (is_issue(state)),
      .expire (expire)
   );

   // Transaction sequencer with registered memory command, acks and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd        <= '0;
         mem_req_q  <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         mem_err_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         streak     <= '0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= ISSUE_D;
                  mem_req_q <= 1'b1;
                  cmd.we    <= bus.d_we;
                  cmd.addr  <= bus.d_addr;
                  cmd.wdata <= bus.d_wdata;
               end else if (grant_i) begin
                  state     <= ISSUE_I;
                  mem_req_q <= 1'b1;
                  cmd.we    <= 1'b0;
                  cmd.addr  <= bus.if_addr;
                  cmd.wdata <= '0;
               end
               if (!bus.if_req || grant_i) begin
                  streak <= '0;
               end else if (grant_d && !bus.halted && (streak != SW'(STARVE_LIMIT))) begin
                  streak <= streak + 1'b1;
               end
            end
            ISSUE_I, ISSUE_D: begin
               if (bus.mem_ready || expire) begin
                  state     <= RESP;
                  mem_req_q <= 1'b0;
                  cmd       <= '0;
                  if (!bus.mem_ready) begin
                     mem_err_q <= 1'b1;
                  end
                  if (state == ISSUE_I) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
                  end else begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= (bus.mem_ready && !cmd.we) ? bus.mem_rdata : '0;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = cmd.we;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;
   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers after a
// programmable number of issue cycles, expected grants and acks are queued in order.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(
      .STARVE_LIMIT (4),
      .TIMEOUT      (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
   } txn_t;

   txn_t        grant_q[$];
   txn_t        ack_q[$];
   int          n_err = 0;
   int          n_chk = 0;
   int          n_acks = 0;
   int unsigned cyc = 0;
   int unsigned last_ack_cyc = 0;
   int unsigned rdy_lat = 1;
   int unsigned issue_cyc = 0;
   bit          spur = 1'b0;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h2002_0005;
      return (a ^ 32'hA5A5_0000) + 32'd1;
   endfunction

   function automatic txn_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit to, input bit err);
      txn_t t;
      t.is_d  = is_d;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      t.rdata = (we || to) ? 32'h0 : mem_model(addr);
      t.err   = err;
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic expect_txn(input txn_t t);
      grant_q.push_back(t);
      ack_q.push_back(t);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural memory: ready on the rdy_lat-th issue cycle (0 = never).
   always @(negedge clk) begin
      if (bus.mem_req) begin
         issue_cyc = issue_cyc + 1;
         if (rdy_lat != 0 && issue_cyc == rdy_lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_model(bus.mem_addr);
         end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
         end
      end else begin
         issue_cyc     = 0;
         bus.mem_ready = spur;
         bus.mem_rdata = spur ? 32'hBAD0_0BAD : 32'h0;
      end
   end

   task automatic monitor();
      logic prev;
      txn_t t;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !prev) begin
            check("grant_expected", 32'(grant_q.size() != 0), 1);
            if (grant_q.size() != 0) begin
               t = grant_q.pop_front();
               check("grant_addr", bus.mem_addr, t.addr);
               check("grant_we", 32'(bus.mem_we), 32'(t.we));
               if (t.we) check("grant_wdata", bus.mem_wdata, t.wdata);
            end
         end
         prev = bus.mem_req;
         if (bus.if_ack || bus.d_ack) begin
            n_acks++;
            last_ack_cyc = cyc;
            check("ack_expected", 32'(ack_q.size() != 0), 1);
            if (ack_q.size() != 0) begin
               t = ack_q.pop_front();
               check("ack_port", 32'({bus.if_ack, bus.d_ack}), t.is_d ? 32'd1 : 32'd2);
               check(t.is_d ? "d_rdata" : "if_rdata", t.is_d ? bus.d_rdata : bus.if_rdata, t.rdata);
               check("mem_err_at_ack", 32'(bus.mem_err), 32'(t.err));
            end
         end
      end
   endtask

   task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] w);
      bit seen;
      seen = 1'b0;
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = w;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus.d_ack;
      end
      check("d_ack_seen", 32'(seen), 1);
      @(posedge clk);
      #1;
      bus.d_req = 1'b0;
   endtask

   task automatic do_if(input logic [31:0] a);
      bit seen;
      seen = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus.if_ack;
      end
      check("if_ack_seen", 32'(seen), 1);
      @(posedge clk);
      #1;
      bus.if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0;
      int          a0;
      int          hits;

      rst         = 1'b1;
      bus.halted  = 1'b0;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 32'(bus.mem_req), 0);
      check("rst_acks", 32'({bus.if_ack, bus.d_ack}), 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_d_rdata", bus.d_rdata, 0);
      check("rst_mem_err", 32'(bus.mem_err), 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fetch with memory ready on the third issue cycle.
      rdy_lat = 3;
      expect_txn(mk(0, 0, 32'h0000_0040, 0, 0, 0));
      t0 = cyc;
      do_if(32'h0000_0040);
      check("if_latency", last_ack_cyc - t0, 4);
      check("if_rdata_held", bus.if_rdata, 32'h2002_0005);

      // Simultaneous requests: data store first, then the fetch.
      rdy_lat = 2;
      expect_txn(mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0));
      expect_txn(mk(0, 0, 32'h0000_004C, 0, 0, 0));
      fork
         do_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
         do_if(32'h0000_004C);
      join

      // Data streak against a pending fetch: D,D,D,D,IF,D,D.
      rdy_lat = 1;
      for (int i = 0; i < 4; i++) expect_txn(mk(1, 0, 32'h400 + 32'(4 * i), 0, 0, 0));
      expect_txn(mk(0, 0, 32'h0000_0048, 0, 0, 0));
      for (int i = 4; i < 6; i++) expect_txn(mk(1, 0, 32'h400 + 32'(4 * i), 0, 0, 0));
      fork
         begin
            for (int i = 0; i < 6; i++) do_d(1'b0, 32'h400 + 32'(4 * i), 32'h0);
         end
         do_if(32'h0000_0048);
      join

      // Halted core: fetch held off, data still served, fetch follows un-halt.
      rdy_lat = 2;
      bus.halted = 1'b1;
      expect_txn(mk(1, 0, 32'h0000_0200, 0, 0, 0));
      expect_txn(mk(0, 0, 32'h0000_0080, 0, 0, 0));
      fork
         do_if(32'h0000_0080);
         begin
            hits = 0;
            repeat (20) begin
               @(negedge clk);
               if (bus.mem_req) hits++;
            end
            check("halted_no_mem_req", 32'(hits), 0);
            do_d(1'b0, 32'h0000_0200, 32'h0);
            bus.halted = 1'b0;
         end
      join

      // Halt raised while a fetch is in flight: it still completes.
      rdy_lat = 4;
      expect_txn(mk(0, 0, 32'h0000_0044, 0, 0, 0));
      fork
         do_if(32'h0000_0044);
         begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            bus.halted = 1'b1;
         end
      join
      bus.halted = 1'b0;

      // mem_ready while idle must be ignored.
      a0 = n_acks;
      spur = 1'b1;
      repeat (10) @(negedge clk);
      spur = 1'b0;
      repeat (3) @(negedge clk);
      check("spurious_ready_no_ack", 32'(n_acks - a0), 0);
      check("spurious_ready_no_req", 32'(bus.mem_req), 0);
      @(posedge clk);
      #1;

      // Memory never answers: abort after TIMEOUT issue cycles.
      rdy_lat = 0;
      expect_txn(mk(1, 0, 32'h0000_0300, 0, 1, 1));
      t0 = cyc;
      do_d(1'b0, 32'h0000_0300, 32'h0);
      check("timeout_latency", last_ack_cyc - t0, 65);
      repeat (5) @(negedge clk);
      check("mem_err_sticky", 32'(bus.mem_err), 1);
      @(posedge clk);
      #1;
      rdy_lat = 1;
      expect_txn(mk(0, 0, 32'h0000_0054, 0, 0, 1));
      do_if(32'h0000_0054);

      // Reset in the middle of a data transaction.
      rdy_lat = 0;
      grant_q.push_back(mk(1, 0, 32'h0000_0500, 0, 1, 1));
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h0000_0500;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("pre_rst_mem_req", 32'(bus.mem_req), 1);
      a0 = n_acks;
      rst = 1'b1;
      #1;
      check("midrst_mem_req", 32'(bus.mem_req), 0);
      check("midrst_d_ack", 32'(bus.d_ack), 0);
      check("midrst_mem_err", 32'(bus.mem_err), 0);
      bus.d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("midrst_no_ack", 32'(n_acks - a0), 0);
      check("midrst_idle_no_req", 32'(bus.mem_req), 0);
      @(posedge clk);
      #1;
      rdy_lat = 2;
      expect_txn(mk(0, 0, 32'h0000_0058, 0, 0, 0));
      t0 = cyc;
      do_if(32'h0000_0058);
      check("post_rst_latency", last_ack_cyc - t0, 3);

      repeat (3) @(negedge clk);
      check("grant_q_drained", 32'(grant_q.size()), 0);
      check("ack_q_drained", 32'(ack_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
